// File: rtl/if_fetch.sv
// Instruction fetch stage: issues one request per instruction and holds the fetched word until decode takes it.
// Optional macro IF_ALIGN_CHECK_EN adds the if_misalign fault path for unaligned PCs.
module if_fetch (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        redirect,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        id_ready,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc4,
   output logic        if_kernel,
   output logic        pc_hold,
   output logic [31:0] fetch_cnt
`ifdef IF_ALIGN_CHECK_EN
   ,
   output logic        if_misalign
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FULL} state_t;

   state_t      state_q, state_d;
   logic        drop_q, drop_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ipc_q, ipc_d;
   logic [31:0] ipc4_q, ipc4_d;
   logic        kernel_q, kernel_d;
   logic [31:0] cnt_q, cnt_d;
   logic        mis_q, mis_d;
   logic        pc_unaligned;

`ifdef IF_ALIGN_CHECK_EN
   assign pc_unaligned = (pc[1:0] != 2'b00);
`else
   logic pc_lo_unused;
   assign pc_lo_unused = ^pc[1:0];
   assign pc_unaligned = 1'b0;
`endif

   assign imem_addr = {1'b0, pc[30:2], 2'b00};
   assign imem_req  = !reset && (state_q == S_REQ) && !pc_unaligned;
   assign pc_hold   = reset || !((state_q == S_FULL) && id_ready);

   always_comb begin
      state_d  = state_q;
      drop_d   = drop_q;
      req_pc_d = req_pc_q;
      valid_d  = valid_q;
      instr_d  = instr_q;
      ipc_d    = ipc_q;
      ipc4_d   = ipc4_q;
      kernel_d = kernel_q;
      cnt_d    = cnt_q;
      mis_d    = mis_q;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (pc_unaligned) begin
               // Fault is reported through the normal FULL handshake so decode sees it in order.
               valid_d  = 1'b1;
               mis_d    = 1'b1;
               instr_d  = 32'd0;
               ipc_d    = pc;
               ipc4_d   = {pc[31], pc[30:0] + 31'd4};
               kernel_d = pc[31];
               state_d  = S_FULL;
            end else if (imem_gnt) begin
               req_pc_d = pc;
               drop_d   = redirect;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               if (drop_q || redirect) begin
                  drop_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  valid_d  = 1'b1;
                  mis_d    = 1'b0;
                  instr_d  = imem_rdata;
                  ipc_d    = req_pc_q;
                  ipc4_d   = {req_pc_q[31], req_pc_q[30:0] + 31'd4};
                  kernel_d = req_pc_q[31];
                  state_d  = S_FULL;
               end
            end else if (redirect) begin
               drop_d = 1'b1;
            end
         end
         S_FULL: begin
            if (redirect) begin
               valid_d = 1'b0;
               mis_d   = 1'b0;
               state_d = S_REQ;
            end else if (id_ready) begin
               valid_d = 1'b0;
               mis_d   = 1'b0;
               cnt_d   = cnt_q + 32'd1;
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         drop_q   <= 1'b0;
         req_pc_q <= 32'd0;
         valid_q  <= 1'b0;
         instr_q  <= 32'd0;
         ipc_q    <= 32'd0;
         ipc4_q   <= 32'd0;
         kernel_q <= 1'b0;
         cnt_q    <= 32'd0;
         mis_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         drop_q   <= drop_d;
         req_pc_q <= req_pc_d;
         valid_q  <= valid_d;
         instr_q  <= instr_d;
         ipc_q    <= ipc_d;
         ipc4_q   <= ipc4_d;
         kernel_q <= kernel_d;
         cnt_q    <= cnt_d;
         mis_q    <= mis_d;
      end
   end

   assign if_valid  = valid_q;
   assign if_instr  = instr_q;
   assign if_pc     = ipc_q;
   assign if_pc4    = ipc4_q;
   assign if_kernel = kernel_q;
   assign fetch_cnt = cnt_q;
`ifdef IF_ALIGN_CHECK_EN
   assign if_misalign = mis_q;
`else
   logic mis_unused;
   assign mis_unused = mis_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic        redirect;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        id_ready;
   logic        if_valid;
   logic [31:0] if_instr, if_pc, if_pc4;
   logic        if_kernel;
   logic        pc_hold;
   logic [31:0] fetch_cnt;
`ifdef IF_ALIGN_CHECK_EN
   logic        if_misalign;
`endif

   int n_chk = 0;
   int n_bad = 0;

   if_fetch dut (
      .clk(clk), .reset(reset), .pc(pc), .redirect(redirect),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_ready(id_ready),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4),
      .if_kernel(if_kernel), .pc_hold(pc_hold), .fetch_cnt(fetch_cnt)
`ifdef IF_ALIGN_CHECK_EN
      , .if_misalign(if_misalign)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts in REQ; grant immediately, data one cycle later, ends in FULL.
   task automatic do_fetch(input string tag, input logic [31:0] p, input logic [31:0] w,
                           input logic [31:0] exp_addr);
      pc = p;
      #1;
      chk({tag, ".req"}, {31'd0, imem_req}, 32'd1);
      chk({tag, ".addr"}, imem_addr, exp_addr);
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      chk({tag, ".wait_req"}, {31'd0, imem_req}, 32'd0);
      chk({tag, ".wait_vld"}, {31'd0, if_valid}, 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = w;
      tick();
      imem_rvalid = 1'b0;
      chk({tag, ".vld"}, {31'd0, if_valid}, 32'd1);
      chk({tag, ".instr"}, if_instr, w);
      chk({tag, ".pc"}, if_pc, p);
   endtask

   initial begin
      reset = 1'b1; pc = 32'd0; redirect = 1'b0; imem_gnt = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = 32'd0; id_ready = 1'b0;
      tick();
      tick();
      chk("rst.vld", {31'd0, if_valid}, 32'd0);
      chk("rst.req", {31'd0, imem_req}, 32'd0);
      chk("rst.hold", {31'd0, pc_hold}, 32'd1);
      chk("rst.cnt", fetch_cnt, 32'd0);
      chk("rst.instr", if_instr, 32'd0);
      reset = 1'b0;
      tick();

      // Basic fetch at PC 0, best-case latency.
      do_fetch("f0", 32'h0000_0000, 32'h2008_0005, 32'h0000_0000);
      chk("f0.pc4", if_pc4, 32'h0000_0004);
      chk("f0.kern", {31'd0, if_kernel}, 32'd0);
      chk("f0.hold", {31'd0, pc_hold}, 32'd1);

      // Decode stalls for three cycles.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall.vld", {31'd0, if_valid}, 32'd1);
         chk("stall.instr", if_instr, 32'h2008_0005);
         chk("stall.pc", if_pc, 32'h0000_0000);
         chk("stall.hold", {31'd0, pc_hold}, 32'd1);
         chk("stall.cnt", fetch_cnt, 32'd0);
      end
      id_ready = 1'b1;
      #1;
      chk("acc.hold", {31'd0, pc_hold}, 32'd0);
      tick();
      id_ready = 1'b0;
      chk("acc.cnt", fetch_cnt, 32'd1);
      chk("acc.vld", {31'd0, if_valid}, 32'd0);
      chk("acc.hold2", {31'd0, pc_hold}, 32'd1);

      // Kernel PC.
      do_fetch("fk", 32'h8000_0004, 32'hA5A5_0001, 32'h0000_0004);
      chk("fk.kern", {31'd0, if_kernel}, 32'd1);
      chk("fk.pc4", if_pc4, 32'h8000_0008);
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
      chk("fk.cnt", fetch_cnt, 32'd2);

      // Redirect in WAIT, response two cycles later is dropped.
      pc = 32'h0000_0100; imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0; redirect = 1'b1;
      tick();
      redirect = 1'b0; pc = 32'h0000_0200;
      tick();
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_rvalid = 1'b0;
      #1;
      chk("rdw.vld", {31'd0, if_valid}, 32'd0);
      chk("rdw.cnt", fetch_cnt, 32'd2);
      chk("rdw.req", {31'd0, imem_req}, 32'd1);
      chk("rdw.addr", imem_addr, 32'h0000_0200);
      tick();
      chk("rdw.vld2", {31'd0, if_valid}, 32'd0);

      // Redirect in FULL beats id_ready.
      do_fetch("f2", 32'h0000_0200, 32'h1111_1111, 32'h0000_0200);
      redirect = 1'b1; id_ready = 1'b1;
      tick();
      redirect = 1'b0; id_ready = 1'b0;
      chk("rdf.vld", {31'd0, if_valid}, 32'd0);
      chk("rdf.cnt", fetch_cnt, 32'd2);

      // Redirect coincident with rvalid.
      pc = 32'h0000_0300; imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; redirect = 1'b1; imem_rdata = 32'h1234_5678;
      tick();
      imem_rvalid = 1'b0; redirect = 1'b0;
      chk("rdc.vld", {31'd0, if_valid}, 32'd0);
      chk("rdc.req", {31'd0, imem_req}, 32'd1);

      // Redirect with grant in REQ.
      pc = 32'h0000_0400; imem_gnt = 1'b1; redirect = 1'b1;
      tick();
      imem_gnt = 1'b0; redirect = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
      tick();
      imem_rvalid = 1'b0;
      chk("rdg.vld", {31'd0, if_valid}, 32'd0);
      chk("rdg.instr", if_instr, 32'h1111_1111);

      // Stray rvalid in REQ is ignored.
      imem_rvalid = 1'b1; imem_rdata = 32'h7777_7777;
      tick();
      imem_rvalid = 1'b0;
      chk("stray.vld", {31'd0, if_valid}, 32'd0);
      chk("stray.req", {31'd0, imem_req}, 32'd1);

      // Reset in WAIT; late response arrives in IDLE.
      pc = 32'h0000_0500; imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0; reset = 1'b1;
      tick();
      chk("rw.req", {31'd0, imem_req}, 32'd0);
      chk("rw.hold", {31'd0, pc_hold}, 32'd1);
      chk("rw.cnt", fetch_cnt, 32'd0);
      chk("rw.instr", if_instr, 32'd0);
      chk("rw.pc", if_pc, 32'd0);
      reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_rvalid = 1'b0;
      chk("rw.vld", {31'd0, if_valid}, 32'd0);
      chk("rw.req2", {31'd0, imem_req}, 32'd1);
      tick();
      chk("rw.vld2", {31'd0, if_valid}, 32'd0);
      chk("rw.instr2", if_instr, 32'd0);

`ifdef IF_ALIGN_CHECK_EN
      pc = 32'h0000_0006;
      #1;
      chk("mis.req", {31'd0, imem_req}, 32'd0);
      tick();
      chk("mis.req2", {31'd0, imem_req}, 32'd0);
      chk("mis.vld", {31'd0, if_valid}, 32'd1);
      chk("mis.flag", {31'd0, if_misalign}, 32'd1);
      chk("mis.pc", if_pc, 32'h0000_0006);
      chk("mis.instr", if_instr, 32'd0);
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
      chk("mis.cnt", fetch_cnt, 32'd1);
`else
      pc = 32'h0000_0006;
      #1;
      chk("una.req", {31'd0, imem_req}, 32'd1);
      chk("una.addr", imem_addr, 32'h0000_0004);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 pc  input  32  current PC from the PC register; bit 31 = supervisor (kernel) flag.
REQ-004 redirect  input  1  one-cycle pulse in the cycle the PC register loads a non-sequential value (branch, J/JR, ILLOP, XADR); new pc is visible the following cycle.
REQ-005 imem_req  output  1  instruction memory request.
REQ-006 imem_addr  output  32  instruction memory byte address.
REQ-007 imem_gnt  input  1  memory accepts request in the cycle imem_req=1 and imem_gnt=1.
REQ-008 imem_rvalid  input  1  read data valid; one response per granted request, arbitrary latency of at least 1 cycle.
REQ-009 imem_rdata  input  32  instruction word.
REQ-010 id_ready  input  1  decode stage accepts if_* outputs when if_valid=1 and id_ready=1.
REQ-011 if_valid  output  1  if_* outputs hold a valid fetched instruction.
REQ-012 if_instr / if_pc / if_pc4  output  32 each  instruction, its PC, and its PC+4 with bit 31 preserved.
REQ-013 if_kernel  output  1  copy of bit 31 of the fetched PC.
REQ-014 pc_hold  output  1  instructs the PC register to hold its value this cycle.
REQ-015 fetch_cnt  output  32  count of instructions accepted by decode; wraps 0xFFFF_FFFF -> 0.
REQ-016 if_misalign  output  1  fetch-alignment fault flag; present only when IF_ALIGN_CHECK_EN is defined.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, FULL.
REQ-018 IDLE: imem_req=0; unconditionally -> REQ next cycle.
REQ-019 REQ: imem_req=1; imem_addr={1'b0, pc[30:2], 2'b00}; on imem_gnt, latch pc into req_pc and -> WAIT; otherwise stay, and imem_addr tracks pc combinationally.
REQ-020 WAIT: imem_req=0; on imem_rvalid with drop flag clear, load if_instr=imem_rdata, if_pc=req_pc, if_pc4={req_pc[31], req_pc[30:0]+4}, if_kernel=req_pc[31], then -> FULL.
REQ-021 FULL: if_valid=1; outputs stable while id_ready=0; on id_ready=1, increment fetch_cnt, clear if_valid and -> REQ.
REQ-022 pc_hold=0 only in a FULL cycle with id_ready=1; pc_hold=1 in every other cycle, including reset.
REQ-023 Best-case latency: REQ entry -> if_valid=1 is 2 cycles (gnt in the REQ cycle, rvalid in the next cycle).
REQ-024 redirect in a REQ cycle where imem_gnt=1: set drop flag and -> WAIT.
REQ-025 redirect in WAIT: set drop flag.
REQ-026 rvalid with drop set, including rvalid coincident with redirect: discard data, clear drop, -> REQ; if_valid stays 0 and fetch_cnt is unchanged.
REQ-027 redirect in FULL: clear if_valid, -> REQ, no fetch_cnt increment, even if id_ready=1 in the same cycle.
REQ-028 redirect in IDLE, or in REQ without gnt: no effect.
REQ-029 imem_rvalid outside WAIT is ignored.

Reset
REQ-030 reset=1 forces state=IDLE, drop=0, if_valid=0, if_instr=0, if_pc=0, if_pc4=0, if_kernel=0, fetch_cnt=0, imem_req=0, pc_hold=1, and if_misalign=0 when IF_ALIGN_CHECK_EN is defined.
REQ-031 reset overrides all other inputs, including in mid-WAIT; the response for the abandoned request is ignored by REQ-029.

Configuration
REQ-032 Macro IF_ALIGN_CHECK_EN defined: in REQ with pc[1:0]!=0, no request is issued (imem_req=0); next cycle if_valid=1, if_misalign=1, if_instr=0, if_pc=pc, -> FULL; acceptance by decode counts in fetch_cnt.
REQ-033 IF_ALIGN_CHECK_EN undefined: port if_misalign is absent; pc[1:0] is ignored and the fetch address is forced word-aligned by REQ-019.

Verification
REQ-034 reset; pc=0x0000_0000; gnt in the REQ cycle; rvalid next cycle with rdata 0x2008_0005 -> if_valid=1 two cycles after REQ entry; if_instr=0x2008_0005; if_pc4=0x0000_0004.
REQ-035 pc=0x8000_0004 -> imem_addr=0x0000_0004; if_kernel=1; if_pc4=0x8000_0008.
REQ-036 id_ready=0 for 3 cycles in FULL -> if_valid, if_instr, if_pc stable; pc_hold=1; fetch_cnt unchanged; id_ready=1 -> pc_hold=0 for 1 cycle; fetch_cnt+1.
REQ-037 redirect in WAIT, rvalid 2 cycles later with 0xDEAD_BEEF -> word discarded; if_valid=0; new REQ with imem_addr = new pc.
REQ-038 reset asserted in WAIT, rvalid arrives during IDLE -> ignored; all outputs at reset values.
REQ-039 IF_ALIGN_CHECK_EN defined, pc=0x0000_0006 -> imem_req never 1; if_valid=1; if_misalign=1; if_pc=0x0000_0006; if_instr=0.
